// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM encodings shared by the ALU arbiter and its datapath.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   OP_MOV..OP_SLT, OP_ILLEGAL  3-bit opcode encodings
//   state_t                     arbiter FSM state encoding (IDLE/EXEC/RESP)
package alu_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_MOV     = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_NOT     = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD     = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_SUB     = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_OR      = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_AND     = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_SLT     = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two request channels and one response channel of the ALU arbiter.
// Latency: n/a (wires only).
// Backpressure: reqN_ready / rsp_ready valid-ready handshakes.
//
// Signals:
//   reqN_valid/ready/op/a/b  (N=0,1)  requester -> arbiter operation
//   rsp_valid/ready/id/data/err       arbiter -> consumer result
// Modports: master = requesters + consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU (MOV/NOT/ADD/SUB/OR/AND/SLT), modulo 2^WIDTH.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   op   opcode, a/b operands, y result
//   The illegal opcode yields 0 here; flagging it is left to the caller.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OPW'(OP_MOV): y = a;
      OPW'(OP_NOT): y = ~a;
      OPW'(OP_ADD): y = a + b;
      OPW'(OP_SUB): y = a - b;
      OPW'(OP_OR):  y = a | b;
      OPW'(OP_AND): y = a & b;
      // Unsigned compare, zero-extended to the full result width.
      OPW'(OP_SLT): y = WIDTH'(a < b);
      default:      y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one of two requesters, runs its op through the ALU, returns a registered result.
// Latency: rsp_valid rises on the second rising edge counting the accept edge; one op per 3 cycles max.
// Backpressure: result is held in RESP until rsp_ready; no request is accepted outside IDLE.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   bus (slave)       req0/req1 valid-ready operation channels, rsp valid-ready result channel
// Build option:
//   ALU_ARBITER_ROUND_ROBIN_EN  defined: 1-bit pointer alternates preference after every accept
//                               undefined: requester 0 always wins ties, no pointer register
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);

  state_t           state;
  state_t           state_nxt;

  logic             grant_any;
  logic             grant_id;
  logic             ready0;
  logic             ready1;
  logic             accept;
  logic             rsp_valid_int;

  logic [OPW-1:0]   cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_id;

  logic [WIDTH-1:0] alu_y;
  logic             cap_illegal;

  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic             rr_ptr;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration: pick the winner among the currently valid requesters.
  // With a single valid requester it always wins; the policy only breaks ties.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = rr_ptr;
    end else begin
      grant_id = bus.req1_valid;
    end
`else
    grant_id = ~bus.req0_valid;
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)        state_nxt = ST_EXEC;
      ST_EXEC:                    state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs decoded from state.
  // Readies are masked by rst so nothing is granted while reset is held; the
  // state register alone would already be IDLE and would otherwise let a grant
  // show during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready0        = 1'b0;
    ready1        = 1'b0;
    rsp_valid_int = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any && !rst) begin
          ready0 = ~grant_id;
          ready1 = grant_id;
        end
      end
      ST_RESP: rsp_valid_int = 1'b1;
      default: ;
    endcase
  end

  assign accept = ready0 | ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_int;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

  // ---------------------------------------------------------------------------
  // Capture registers: the ALU only ever sees these, so requesters may change
  // or drop their inputs right after the accept edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_op <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
      cap_id <= 1'b0;
    end else if (accept) begin
      cap_op <= grant_id ? bus.req1_op : bus.req0_op;
      cap_a  <= grant_id ? bus.req1_a  : bus.req0_a;
      cap_b  <= grant_id ? bus.req1_b  : bus.req0_b;
      cap_id <= grant_id;
    end
  end

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  // Preference moves to the requester that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant_id;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Datapath: one ALU fed from the captured operands.
  // ---------------------------------------------------------------------------
  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op (cap_op),
    .a  (cap_a),
    .b  (cap_b),
    .y  (alu_y)
  );

  assign cap_illegal = (cap_op == OPW'(OP_ILLEGAL));

  // Result registers load exactly once, in EXEC, and then hold through RESP
  // until the consumer takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_id_q   <= cap_id;
      rsp_data_q <= cap_illegal ? '0 : alu_y;
      rsp_err_q  <= cap_illegal;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized checks of alu_arbiter against a behavioural model.
// Drives inputs and samples outputs 1 time unit after the rising edge.
// Define ALU_ARBITER_ROUND_ROBIN_EN for both bench and RTL to check the round-robin build.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic pref;  // model: requester preferred on a tie
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic straight from the opcode table, modulo 2^32.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return ~a;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a | b;
      3'd5:    return a & b;
      3'd6:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      return pref;
`else
      return 1'b0;
`endif
    end
    return v1;
  endfunction

  task automatic set_req(input logic id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (!id) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE with rsp_ready=1; requests already presented.
  task automatic run_txn(input string tag, input bit keep, output logic w,
                         output logic [31:0] obs_data);
    logic [2:0]  op;
    logic [31:0] a, b, exp_d;
    logic        exp_e;
    #1;
    w     = ref_winner(bus.req0_valid, bus.req1_valid);
    op    = w ? bus.req1_op : bus.req0_op;
    a     = w ? bus.req1_a  : bus.req0_a;
    b     = w ? bus.req1_b  : bus.req0_b;
    exp_d = ref_alu(op, a, b);
    exp_e = (op == 3'b111);
    chk({tag, "/grant"}, {30'd0, bus.req1_ready, bus.req0_ready}, w ? 32'd2 : 32'd1);
    tick();  // accept edge
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    pref = ~w;
`endif
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    #1;
    chk({tag, "/exec_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "/exec_ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    chk({tag, "/rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, "/rsp_id"},    {31'd0, bus.rsp_id}, {31'd0, w});
    chk({tag, "/rsp_data"},  bus.rsp_data, exp_d);
    chk({tag, "/rsp_err"},   {31'd0, bus.rsp_err}, {31'd0, exp_e});
    obs_data = bus.rsp_data;
    tick();  // consumed
    chk({tag, "/done"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        w;
    logic [31:0] d;
    logic [3:0]  seq;
    logic [31:0] ra, rb, exp_hold;
    int          sel;

    // ---- reset: requests held valid must not be granted while rst=1 ----
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    pref = 1'b0;
`endif
    tick();
    tick();
    chk("rst/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst/rsp_id",    {31'd0, bus.rsp_id}, 32'd0);
    chk("rst/rsp_data",  bus.rsp_data, 32'd0);
    chk("rst/rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst/readies",   {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;

    // ---- contention: both valid continuously, pointer fresh from reset ----
    set_req(0, OP_ADD, 32'd1, 32'd2);
    set_req(1, OP_SUB, 32'd10, 32'd3);
    for (int i = 0; i < 4; i++) begin
      run_txn("contend", 1'b1, w, d);
      seq[i] = w;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    chk("contend/seq", {28'd0, seq}, 32'h0000000a);
`else
    chk("contend/seq", {28'd0, seq}, 32'h00000000);
`endif

    // ---- directed single-requester operations ----
    set_req(0, OP_ADD, 32'd5, 32'd7);
    run_txn("add", 1'b0, w, d);
    chk("add/value", d, 32'd12);

    set_req(1, OP_SUB, 32'd0, 32'd1);
    run_txn("sub_wrap", 1'b0, w, d);
    chk("sub_wrap/value", d, 32'hFFFFFFFF);

    set_req(1, OP_SLT, 32'd3, 32'd9);
    run_txn("slt_true", 1'b0, w, d);
    chk("slt_true/value", d, 32'd1);

    set_req(0, OP_SLT, 32'd9, 32'd3);
    run_txn("slt_false", 1'b0, w, d);
    chk("slt_false/value", d, 32'd0);

    set_req(0, OP_ILLEGAL, 32'hDEADBEEF, 32'h12345678);
    run_txn("illegal", 1'b0, w, d);
    chk("illegal/value", d, 32'd0);

    // ---- backpressure: result held for 5 stalled cycles, no new accept ----
    bus.rsp_ready = 1'b0;
    ra = $urandom;
    rb = $urandom;
    exp_hold = ra | rb;
    set_req(0, OP_OR, ra, rb);
    #1;
    chk("stall/grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    pref = 1'b1;
`endif
    bus.req0_valid = 1'b0;
    tick();  // now in RESP
    set_req(0, OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
    set_req(1, OP_NOT, 32'h0, 32'h0);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall/rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall/rsp_data",  bus.rsp_data, exp_hold);
      chk("stall/rsp_id",    {31'd0, bus.rsp_id}, 32'd0);
      chk("stall/readies",   {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    tick();
    chk("stall/release", {31'd0, bus.rsp_valid}, 32'd0);

    // ---- reset pulsed during EXEC: operation vanishes, fresh req0 next ----
    set_req(1, OP_MOV, 32'h55AA55AA, 32'h0);
    #1;
    chk("rstx/grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
    tick();
    bus.req1_valid = 1'b0;
    rst = 1'b1;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    pref = 1'b0;
`endif
    set_req(0, OP_ADD, 32'd20, 32'd22);
    #1;
    chk("rstx/rsp_valid_in", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rstx/readies_in",   {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    chk("rstx/rsp_valid_held", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("rstx/rsp_data_clr", bus.rsp_data, 32'd0);
    rst = 1'b0;
    run_txn("rstx_fresh", 1'b0, w, d);
    chk("rstx_fresh/value", d, 32'd42);

    // ---- randomized traffic, random contention pattern ----
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(1, 3);
      if (sel[0]) begin
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        set_req(0, 3'($urandom_range(0, 7)), ra, rb);
      end
      if (sel[1]) begin
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        set_req(1, 3'($urandom_range(0, 7)), ra, rb);
      end
      run_txn("rand", 1'b0, w, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
